w5300_rx_frame_buffer: RTL and testbench



---
 rtl/w5300_rx_frame_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_w5300_rx_frame_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_rx_frame_buffer.sv
// Ping-pong capture of W5300 socket RX FIFO words with UDP info-header parsing
// and a valid/ready payload word stream carrying byte keep and last.
module w5300_rx_frame_buffer #(
  parameter int unsigned ETH_RX_BUFFER_WIDTH = 16,
  parameter int unsigned BANK_AW             = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_req,
  input  logic [ETH_RX_BUFFER_WIDTH-1:0] wr_addr,
  input  logic [15:0]                    wr_data,
  input  logic                           wr_done,
  output logic                           buf_free,
  output logic                           info_valid,
  output logic [31:0]                    peer_ip,
  output logic [15:0]                    peer_port,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [15:0]                    m_data,
  output logic [1:0]                     m_keep,
  output logic                           m_last,
  output logic                           err
);
  localparam int unsigned CW        = BANK_AW + 1;
  localparam int unsigned RAM_AW    = BANK_AW + 1;
  localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_DRAINING} bank_st_t;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHECK, S_STREAM, S_RELEASE} rd_st_t;

  logic [15:0] mem [RAM_DEPTH];

  bank_st_t         bank_st [2];
  bank_st_t         bank_st_d [2];
  logic [CW-1:0]    cnt [2];
  logic [CW-1:0]    cnt_d [2];
  logic             wb, wb_d, rb;

  rd_st_t           state;
  logic [1:0]       hdr_cnt;
  logic [BANK_AW-1:0] beat, last_beat;
  logic             odd;

  logic             wr_ovf_c, wr_blocked_c, wr_en_c, wr_err_c;
  logic [CW-1:0]    wr_len_c;
  logic             claim_c, release_c, accept_c, len_err_c;
  logic [CW-1:0]    cnt_rb_c;
  logic [16:0]      nw_c;
  logic             rd_en_c;
  logic [BANK_AW-1:0] rd_word_c, beat_nx_c;

  // Write-side qualification
  assign wr_ovf_c     = |(wr_addr >> BANK_AW);
  assign wr_blocked_c = (bank_st[wb] == B_FULL) || (bank_st[wb] == B_DRAINING);
  assign wr_en_c      = wr_req && !wr_blocked_c && !wr_ovf_c;
  assign wr_err_c     = wr_req && (wr_blocked_c || wr_ovf_c);
  assign wr_len_c     = CW'(wr_addr[BANK_AW-1:0]) + CW'(1);

  assign claim_c   = (state == S_IDLE) && (bank_st[rb] == B_FULL);
  assign release_c = (state == S_RELEASE);
  assign accept_c  = m_valid && m_ready;
  assign beat_nx_c = beat + BANK_AW'(1);

  // In CHECK the RAM output register holds header word 3 (payload byte size)
  assign cnt_rb_c  = cnt[rb];
  assign nw_c      = (17'(m_data) + 17'd1) >> 1;
  assign len_err_c = (cnt_rb_c < CW'(4)) || (nw_c > 17'(cnt_rb_c - CW'(4)));

  always_comb begin
    bank_st_d = bank_st;
    cnt_d     = cnt;
    wb_d      = wb;
    if (wr_en_c) begin
      bank_st_d[wb] = B_FILLING;
      if (bank_st[wb] == B_FREE || wr_len_c > cnt[wb]) cnt_d[wb] = wr_len_c;
    end
    if (wr_done && bank_st[wb] == B_FILLING) begin
      bank_st_d[wb] = B_FULL;
      wb_d          = ~wb;
    end
    if (claim_c)   bank_st_d[rb] = B_DRAINING;
    if (release_c) bank_st_d[rb] = B_FREE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= B_FREE;
      bank_st[1] <= B_FREE;
      cnt[0]     <= '0;
      cnt[1]     <= '0;
      wb         <= 1'b0;
      buf_free   <= 1'b1;
    end else begin
      bank_st  <= bank_st_d;
      cnt      <= cnt_d;
      wb       <= wb_d;
      buf_free <= (bank_st_d[wb_d] == B_FREE) || (bank_st_d[wb_d] == B_FILLING);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[{wb, wr_addr[BANK_AW-1:0]}] <= wr_data;
  end

  // RAM output register doubles as the held output beat: it only advances on accept
  always_comb begin
    rd_en_c   = 1'b0;
    rd_word_c = '0;
    case (state)
      S_HDR: begin
        rd_en_c   = 1'b1;
        rd_word_c = BANK_AW'(hdr_cnt);
      end
      S_CHECK: begin
        rd_en_c   = 1'b1;
        rd_word_c = BANK_AW'(4);
      end
      S_STREAM: begin
        rd_en_c   = accept_c && !m_last;
        rd_word_c = beat + BANK_AW'(5);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          m_data <= '0;
    else if (rd_en_c) m_data <= mem[{rb, rd_word_c}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rb         <= 1'b0;
      hdr_cnt    <= '0;
      beat       <= '0;
      last_beat  <= '0;
      odd        <= 1'b0;
      info_valid <= 1'b0;
      peer_ip    <= '0;
      peer_port  <= '0;
      m_valid    <= 1'b0;
      m_keep     <= '0;
      m_last     <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= wr_err_c;
      case (state)
        S_IDLE: begin
          if (claim_c) begin
            state   <= S_HDR;
            hdr_cnt <= '0;
          end
        end
        S_HDR: begin
          hdr_cnt <= hdr_cnt + 2'd1;
          case (hdr_cnt)
            2'd1: peer_ip[31:16] <= m_data;
            2'd2: peer_ip[15:0]  <= m_data;
            2'd3: begin
              peer_port <= m_data;
              state     <= S_CHECK;
            end
            default: ;
          endcase
        end
        S_CHECK: begin
          odd       <= m_data[0];
          last_beat <= BANK_AW'(nw_c - 17'd1);
          beat      <= '0;
          if (len_err_c) begin
            err   <= 1'b1;
            state <= S_RELEASE;
          end else if (m_data == 16'd0) begin
            state <= S_RELEASE;
          end else begin
            info_valid <= 1'b1;
            m_valid    <= 1'b1;
            m_last     <= (nw_c == 17'd1);
            m_keep     <= (nw_c == 17'd1 && m_data[0]) ? 2'b10 : 2'b11;
            state      <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (m_ready) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              m_keep  <= '0;
              state   <= S_RELEASE;
            end else begin
              beat   <= beat_nx_c;
              m_last <= (beat_nx_c == last_beat);
              m_keep <= (beat_nx_c == last_beat && odd) ? 2'b10 : 2'b11;
            end
          end
        end
        S_RELEASE: begin
          info_valid <= 1'b0;
          rb         <= ~rb;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_w5300_rx_frame_buffer.sv
// Bench for w5300_rx_frame_buffer: directed frames with random payloads,
// checked against a frame-level reference model of the expected beats.
module tb_w5300_rx_frame_buffer;
  localparam int unsigned AW = 16;

  logic        clk = 1'b0;
  logic        rst, wr_req, wr_done, m_ready;
  logic [AW-1:0] wr_addr;
  logic [15:0] wr_data;
  logic        buf_free, info_valid, m_valid, m_last, err;
  logic [31:0] peer_ip;
  logic [15:0] peer_port, m_data;
  logic [1:0]  m_keep;

  w5300_rx_frame_buffer #(.ETH_RX_BUFFER_WIDTH(AW), .BANK_AW(10)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .buf_free(buf_free), .info_valid(info_valid),
    .peer_ip(peer_ip), .peer_port(peer_port), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] port;
    logic        last;
    logic [1:0]  keep;
    logic [15:0] data;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       got_q[$];
  logic [15:0] wq[$];
  int          compares = 0;
  int          fails = 0;
  int          err_seen = 0;
  int          err_exp = 0;
  logic        hold_v = 1'b0;
  beat_t       hold_b;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] want);
    compares++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  // Observe every cycle: accepted beats, err pulses, hold stability under backpressure
  always @(negedge clk) begin
    beat_t cur;
    cur = {peer_ip, peer_port, m_last, m_keep, m_data};
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (err) err_seen++;
      if (hold_v) chk("hold", 80'({m_valid, cur}), 80'({1'b1, hold_b}));
      if (m_valid) chk("info_valid", 80'(info_valid), 80'(1));
      if (m_valid && m_ready) got_q.push_back(cur);
      hold_v = m_valid && !m_ready;
      hold_b = cur;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic build(input logic [31:0] ip, input logic [15:0] port,
                       input logic [15:0] size, input int npay);
    wq.delete();
    wq.push_back(ip[31:16]);
    wq.push_back(ip[15:0]);
    wq.push_back(port);
    wq.push_back(size);
    for (int i = 0; i < npay; i++) wq.push_back(16'($urandom));
  endtask

  // Reference: a frame yields ceil(size/2) beats from word 4 on, or an error
  task automatic model_frame();
    int n, size, nw;
    logic [31:0] ip;
    n = wq.size();
    if (n < 4) begin
      err_exp++;
      return;
    end
    size = int'(wq[3]);
    nw   = (size + 1) / 2;
    ip   = {wq[0], wq[1]};
    if (nw > n - 4) begin
      err_exp++;
      return;
    end
    for (int i = 0; i < nw; i++)
      exp_q.push_back({ip, wq[2], (i == nw - 1),
                       ((i == nw - 1) && (size % 2 == 1)) ? 2'b10 : 2'b11, wq[4 + i]});
  endtask

  task automatic send();
    for (int i = 0; i < wq.size(); i++) begin
      wr_req  = 1'b1;
      wr_addr = AW'(i);
      wr_data = wq[i];
      cyc(1);
    end
    wr_req  = 1'b0;
    wr_done = 1'b1;
    cyc(1);
    wr_done = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    chk("beat_wait", 80'(got_q.size() >= n), 80'(1));
  endtask

  task automatic check_beats(input string tag);
    int n;
    chk({tag, "_count"}, 80'(got_q.size()), 80'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, 80'(got_q[i]), 80'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; wr_done = 1'b0; m_ready = 1'b0;
    wr_addr = '0; wr_data = '0;
    cyc(3);
    chk("reset", 80'({buf_free, info_valid, peer_ip, peer_port, m_valid, m_data, m_keep, m_last, err}),
        80'({1'b1, 70'd0}));
    rst = 1'b0;
    cyc(2);

    // 1: even size, exact fit, first beat 7 cycles after wr_done, back-to-back beats
    m_ready = 1'b1;
    wq.delete();
    wq = '{16'hC0A8, 16'h0102, 16'h1388, 16'h0006, 16'h0102, 16'h0304, 16'h0506};
    model_frame();
    send();
    cyc(5);
    chk("lat_early", 80'(m_valid), 80'(0));
    cyc(1);
    chk("lat_first", 80'(m_valid), 80'(1));
    chk("t1_ip_port", 80'({peer_ip, peer_port}), 80'({32'hC0A80102, 16'h1388}));
    cyc(3);
    chk("b2b", 80'(got_q.size()), 80'(3));
    cyc(3);
    check_beats("t1");

    // 2: odd size, final beat keeps only the upper byte
    wq.delete();
    wq = '{16'h0A00, 16'h0001, 16'h0035, 16'h0005, 16'hAABB, 16'hCCDD, 16'hEE00};
    model_frame();
    send();
    wait_beats(3, 40);
    cyc(3);
    check_beats("t2");

    // 3: ping-pong with both banks held, third frame rejected
    m_ready = 1'b0;
    build($urandom, 16'($urandom), 16'd8, 4);
    model_frame();
    send();
    build($urandom, 16'($urandom), 16'd7, 5);
    model_frame();
    send();
    cyc(2);
    chk("pp_full", 80'(buf_free), 80'(0));
    wr_req = 1'b1; wr_addr = '0; wr_data = 16'hDEAD;
    cyc(1);
    wr_req = 1'b0;
    err_exp++;
    cyc(3);
    chk("pp_err", 80'(err_seen), 80'(err_exp));
    m_ready = 1'b1;
    wait_beats(8, 200);
    cyc(4);
    check_beats("t3");
    chk("pp_free", 80'(buf_free), 80'(1));

    // 4: random backpressure on an 8-word frame
    build($urandom, 16'($urandom), 16'(15 + $urandom_range(0, 1)), 8);
    model_frame();
    send();
    for (int k = 0; k < 400 && got_q.size() < 8; k++) begin
      m_ready = 1'($urandom);
      cyc(1);
    end
    m_ready = 1'b1;
    cyc(4);
    check_beats("t4");

    // 5: length error, too-short frame, zero size
    build($urandom, 16'($urandom), 16'd40, 2);
    model_frame();
    send();
    cyc(15);
    check_beats("t5_len");
    chk("t5_err", 80'(err_seen), 80'(err_exp));
    chk("t5_free", 80'(buf_free), 80'(1));
    wq.delete();
    wq = '{16'h1111, 16'h2222, 16'h3333};
    model_frame();
    send();
    cyc(15);
    check_beats("t5_short");
    chk("t5_short_err", 80'(err_seen), 80'(err_exp));
    build($urandom, 16'($urandom), 16'd0, 3);
    model_frame();
    send();
    cyc(15);
    check_beats("t5_zero");
    chk("t5_zero_err", 80'(err_seen), 80'(err_exp));

    // 6: reset mid-stream, then a clean frame
    build($urandom, 16'($urandom), 16'd16, 8);
    model_frame();
    send();
    wait_beats(2, 40);
    rst = 1'b1;
    cyc(1);
    chk("t6_reset", 80'({buf_free, info_valid, peer_ip, peer_port, m_valid, m_data, m_keep, m_last, err}),
        80'({1'b1, 70'd0}));
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    cyc(2);
    build($urandom, 16'($urandom), 16'(9 + $urandom_range(0, 1)), 5);
    model_frame();
    send();
    wait_beats(5, 40);
    cyc(3);
    check_beats("t6");
    chk("final_err", 80'(err_seen), 80'(err_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
